// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : Parallel-in/serial-out transmitter with a valid/ready word load,
//            stallable shift and registered serial output with frame markers.
// Revision : 1.0  initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] c_state_idle  = 1'b0;
  localparam logic [0:0] c_state_shift = 1'b1;

  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             sout_first_q, sout_first_d;
  logic             sout_last_q, sout_last_d;

  logic             cnt_is_last;
  logic             load_accept;
  logic [WIDTH-1:0] shreg_shifted;
  logic             next_head;

  // The output end of the shift register depends on bit order; the opposite
  // end is zero-filled as bits are consumed.
  if (MSB_FIRST) begin : g_msb_first
    assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    assign next_head     = shreg_d[WIDTH-1];
  end else begin : g_lsb_first
    assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    assign next_head     = shreg_d[0];
  end

  assign cnt_is_last = (cnt_q == c_last_idx);
  assign load_ready  = (state_q == c_state_idle) |
                       ((state_q == c_state_shift) & cnt_is_last & shift_en);
  assign load_accept = load_valid & load_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;

    if (load_accept) begin
      // Also covers the gapless reload on the edge that consumes the last bit.
      state_d = c_state_shift;
      shreg_d = din;
      cnt_d   = '0;
    end else if ((state_q == c_state_shift) && shift_en) begin
      shreg_d = shreg_shifted;
      if (cnt_is_last) begin
        state_d = c_state_idle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + c_cnt_one;
      end
    end
  end

  // Outputs are registered from the next-state view so they line up with
  // the bit the frame will present after this edge.
  always_comb begin
    sout_valid_d = (state_d == c_state_shift);
    sout_d       = sout_valid_d & next_head;
    sout_first_d = sout_valid_d & (cnt_d == '0);
    sout_last_d  = sout_valid_d & (cnt_d == c_last_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= c_state_idle;
      shreg_q      <= '0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_first_q <= 1'b0;
      sout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_first_q <= sout_first_d;
      sout_last_q  <= sout_last_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_first = sout_first_q;
  assign sout_last  = sout_last_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Purpose  : Scoreboard bench for piso_serializer, MSB-first and LSB-first.
// Revision : 1.0  initial release
// ============================================================================
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic       shift_en;

  logic [7:0] din_a;
  logic       load_valid_a, load_ready_a;
  logic       sout_a, sout_valid_a, sout_first_a, sout_last_a;

  logic [7:0] din_b;
  logic       load_valid_b, load_ready_b;
  logic       sout_b, sout_valid_b, sout_first_b, sout_last_b;

  int n_checks = 0;
  int n_errors = 0;

  // Each entry: {bit, first, last} in transmission order.
  logic [2:0] exp_a[$];
  logic [2:0] exp_b[$];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din_a),
    .load_valid (load_valid_a),
    .load_ready (load_ready_a),
    .shift_en   (shift_en),
    .sout       (sout_a),
    .sout_valid (sout_valid_a),
    .sout_first (sout_first_a),
    .sout_last  (sout_last_a)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .din        (din_b),
    .load_valid (load_valid_b),
    .load_ready (load_ready_b),
    .shift_en   (shift_en),
    .sout       (sout_b),
    .sout_valid (sout_valid_b),
    .sout_first (sout_first_b),
    .sout_last  (sout_last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // seq holds hand-computed serial bits, leftmost bit sent first.
  task automatic push_seq(input bit to_b, input logic [7:0] seq, input int n);
    logic [2:0] e;
    for (int i = 0; i < n; i++) begin
      e = {seq[7-i], (i == 0), (i == 7)};
      if (to_b) exp_b.push_back(e);
      else      exp_a.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, " sout"},       {31'd0, sout_a},       32'd0);
    chk({tag, " sout_valid"}, {31'd0, sout_valid_a}, 32'd0);
    chk({tag, " sout_first"}, {31'd0, sout_first_a}, 32'd0);
    chk({tag, " sout_last"},  {31'd0, sout_last_a},  32'd0);
  endtask

  // Monitors: a bit is consumed at the coming edge when valid and shift_en.
  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst && sout_valid_a && shift_en) begin
      if (exp_a.size() == 0) begin
        chk("msb unexpected bit", 32'd1, 32'd0);
      end else begin
        e = exp_a.pop_front();
        chk("msb sout",  {31'd0, sout_a},       {31'd0, e[2]});
        chk("msb first", {31'd0, sout_first_a}, {31'd0, e[1]});
        chk("msb last",  {31'd0, sout_last_a},  {31'd0, e[0]});
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst && sout_valid_b && shift_en) begin
      if (exp_b.size() == 0) begin
        chk("lsb unexpected bit", 32'd1, 32'd0);
      end else begin
        e = exp_b.pop_front();
        chk("lsb sout",  {31'd0, sout_b},       {31'd0, e[2]});
        chk("lsb first", {31'd0, sout_first_b}, {31'd0, e[1]});
        chk("lsb last",  {31'd0, sout_last_b},  {31'd0, e[0]});
      end
    end
  end

  initial begin
    #200000;
    chk("watchdog timeout", 32'd1, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    rst          = 1'b1;
    shift_en     = 1'b1;
    din_a        = 8'h00;
    load_valid_a = 1'b0;
    din_b        = 8'h00;
    load_valid_b = 1'b0;
    tick();
    tick();
    chk_idle_a("reset");
    chk("reset lsb sout_valid", {31'd0, sout_valid_b}, 32'd0);
    rst = 1'b0;
    chk("idle load_ready", {31'd0, load_ready_a}, 32'd1);

    // 1: A5 MSB first
    push_seq(1'b0, 8'b1010_0101, 8);
    din_a = 8'hA5; load_valid_a = 1'b1;
    tick();
    load_valid_a = 1'b0;
    chk("t1 first bit valid", {31'd0, sout_valid_a}, 32'd1);
    repeat (8) tick();
    chk_idle_a("t1 end");

    // 2: 01 LSB first
    push_seq(1'b1, 8'b1000_0000, 8);
    din_b = 8'h01; load_valid_b = 1'b1;
    tick();
    load_valid_b = 1'b0;
    repeat (8) tick();
    chk("t2 end lsb valid", {31'd0, sout_valid_b}, 32'd0);

    // 3: back-to-back F0, 0F with load_valid held
    push_seq(1'b0, 8'b1111_0000, 8);
    push_seq(1'b0, 8'b0000_1111, 8);
    din_a = 8'hF0; load_valid_a = 1'b1;
    tick();
    din_a = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3 load_ready bit%0d", i), {31'd0, load_ready_a}, (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    load_valid_a = 1'b0;
    chk("t3 no gap valid", {31'd0, sout_valid_a}, 32'd1);
    chk("t3 no gap first", {31'd0, sout_first_a}, 32'd1);
    repeat (8) tick();
    chk_idle_a("t3 end");

    // 4: C3 with a 3-cycle stall on bit 2
    push_seq(1'b0, 8'b1100_0011, 8);
    din_a = 8'hC3; load_valid_a = 1'b1;
    tick();
    load_valid_a = 1'b0;
    repeat (2) tick();
    shift_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4 stall sout",  {31'd0, sout_a},       32'd0);
      chk("t4 stall valid", {31'd0, sout_valid_a}, 32'd1);
      chk("t4 stall first", {31'd0, sout_first_a}, 32'd0);
      chk("t4 stall cnt",   {29'd0, dut.cnt_q},    32'd2);
    end
    shift_en = 1'b1;
    repeat (6) tick();
    chk_idle_a("t4 end");

    // 5: 55 offered while busy on bit 3 of 96
    push_seq(1'b0, 8'b1001_0110, 8);
    din_a = 8'h96; load_valid_a = 1'b1;
    tick();
    load_valid_a = 1'b0;
    repeat (3) tick();
    push_seq(1'b0, 8'b0101_0101, 8);
    din_a = 8'h55; load_valid_a = 1'b1;
    for (int i = 3; i < 8; i++) begin
      chk($sformatf("t5 load_ready bit%0d", i), {31'd0, load_ready_a}, (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    load_valid_a = 1'b0;
    chk("t5 reload first", {31'd0, sout_first_a}, 32'd1);
    repeat (8) tick();
    chk_idle_a("t5 end");

    // 6: reset while bit 4 of E7 is presented, then 81
    push_seq(1'b0, 8'b1110_0111, 4);
    din_a = 8'hE7; load_valid_a = 1'b1;
    tick();
    load_valid_a = 1'b0;
    repeat (4) tick();
    shift_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_a("t6 after reset");
    chk("t6 state idle", {31'd0, dut.state_q}, 32'd0);
    chk("t6 load_ready", {31'd0, load_ready_a}, 32'd1);
    shift_en = 1'b1;
    push_seq(1'b0, 8'b1000_0001, 8);
    din_a = 8'h81; load_valid_a = 1'b1;
    tick();
    load_valid_a = 1'b0;
    chk("t6 restart first", {31'd0, sout_first_a}, 32'd1);
    repeat (8) tick();
    chk_idle_a("t6 end");

    chk("msb queue drained", exp_a.size(), 32'd0);
    chk("lsb queue drained", exp_b.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
